// File: rtl/nn_reset_sequencer_if.sv
// Handshake bundle between the staged reset sequencer (master) and the blocks it sequences (slave).
interface nn_reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    localparam int ERR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  all_ready;
    logic                  busy;
    logic                  seq_err;
    logic [ERR_W-1:0]      err_stage;
    logic [2:0]            state_o;

    modport master (
        input  soft_reset_req, stage_ready,
        output stage_reset, all_ready, busy, seq_err, err_stage, state_o
    );

    modport slave (
        output soft_reset_req, stage_ready,
        input  stage_reset, all_ready, busy, seq_err, err_stage, state_o
    );
endinterface

// File: rtl/nn_reset_sequencer.sv
// Staged reset controller: releases per-block resets in index order, gated by each block's ready ack.
// Optional NN_RSTSEQ_ORDERED_ASSERT_EN: a soft reset in RUN re-asserts stages in reverse order (DRAIN).
module nn_reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 5,
    parameter int STAGE_DELAY = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    nn_reset_sequencer_if.master    seq
);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int MAX_A   = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int MAX_CNT = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_GAP      = 3'd3,
        ST_RUN      = 3'd4,
        ST_ERROR    = 3'd5,
        ST_DRAIN    = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             drop_any;
    logic [IDX_W-1:0] drop_idx;
    logic             restartable;

    assign seq.state_o = state;
    assign restartable = (state == ST_HOLD) || (state == ST_RELEASE) ||
                         (state == ST_WAIT_ACK) || (state == ST_GAP);

    // Lowest-index stage whose ready is low; only consulted once every stage is up.
    always_comb begin
        drop_any = 1'b0;
        drop_idx = '0;
        for (int unsigned i = NUM_STAGES; i > 0; i--) begin
            if (!seq.stage_ready[i-1]) begin
                drop_any = 1'b1;
                drop_idx = IDX_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_HOLD;
            cnt             <= '0;
            idx             <= '0;
            seq.stage_reset <= '1;
            seq.all_ready   <= 1'b0;
            seq.busy        <= 1'b1;
            seq.seq_err     <= 1'b0;
            seq.err_stage   <= '0;
        end else if (restartable && seq.soft_reset_req) begin
            state           <= ST_HOLD;
            cnt             <= '0;
            seq.stage_reset <= '1;
            seq.busy        <= 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_RELEASE;
                        idx   <= '0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    seq.stage_reset[idx] <= 1'b0;
                    state                <= ST_WAIT_ACK;
                    cnt                  <= '0;
                end

                ST_WAIT_ACK: begin
                    if (seq.stage_ready[idx]) begin
                        if (idx == IDX_LAST) begin
                            state         <= ST_RUN;
                            seq.all_ready <= 1'b1;
                            seq.busy      <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                            cnt   <= '0;
                        end
                    end else if (cnt == ACK_LAST) begin
                        state           <= ST_ERROR;
                        seq.stage_reset <= '1;
                        seq.seq_err     <= 1'b1;
                        seq.err_stage   <= idx;
                        seq.all_ready   <= 1'b0;
                        seq.busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        idx   <= idx + 1'b1;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (seq.soft_reset_req) begin
                        seq.all_ready <= 1'b0;
                        seq.busy      <= 1'b1;
                        cnt           <= '0;
`ifdef NN_RSTSEQ_ORDERED_ASSERT_EN
                        // Highest stage goes back into reset on the entry edge itself.
                        seq.stage_reset[IDX_LAST] <= 1'b1;
                        idx                       <= IDX_LAST;
                        state                     <= (NUM_STAGES == 1) ? ST_HOLD : ST_DRAIN;
`else
                        seq.stage_reset <= '1;
                        state           <= ST_HOLD;
`endif
                    end else if (drop_any) begin
                        state           <= ST_ERROR;
                        seq.stage_reset <= '1;
                        seq.seq_err     <= 1'b1;
                        seq.err_stage   <= drop_idx;
                        seq.all_ready   <= 1'b0;
                        seq.busy        <= 1'b0;
                    end
                end

                ST_ERROR: begin
                    if (seq.soft_reset_req) begin
                        state       <= ST_HOLD;
                        cnt         <= '0;
                        idx         <= '0;
                        seq.seq_err <= 1'b0;
                        seq.busy    <= 1'b1;
                    end
                end

`ifdef NN_RSTSEQ_ORDERED_ASSERT_EN
                ST_DRAIN: begin
                    if (cnt == GAP_LAST) begin
                        seq.stage_reset[idx - 1'b1] <= 1'b1;
                        cnt                         <= '0;
                        if (idx == IDX_W'(1)) begin
                            state <= ST_HOLD;
                            idx   <= '0;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    state           <= ST_HOLD;
                    cnt             <= '0;
                    idx             <= '0;
                    seq.stage_reset <= '1;
                    seq.all_ready   <= 1'b0;
                    seq.busy        <= 1'b1;
                end
            endcase
        end
    end
endmodule
